// File: rtl/tone_period_meter.sv
// tone_period_meter: measures the clk-cycle period between consecutive rising
// edges of an asynchronous square wave, classifies the result against the
// nominal 1kHz and 800Hz tone periods, and hands it out over valid/ready with
// loss-of-signal and sticky overrun flags.
`timescale 1ns/1ps
module tone_period_meter #(
  parameter int CNT_W   = 20,
  parameter int P_1KHZ  = 25000,
  parameter int P_800HZ = 31250,
  parameter int TOL     = 250,
  parameter int TIMEOUT = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic             match_1khz,
  output logic             match_800hz,
  output logic             no_signal,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEAS = 2'd1;
  localparam logic [1:0] S_LOST = 2'd2;

  // Counter value on which an edge-free cycle declares loss of signal.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // One extra bit keeps |candidate - nominal| free of wrap-around.
  localparam logic [CNT_W:0]   P1_W     = (CNT_W + 1)'(P_1KHZ);
  localparam logic [CNT_W:0]   P8_W     = (CNT_W + 1)'(P_800HZ);
  localparam logic [CNT_W:0]   TOL_W    = (CNT_W + 1)'(TOL);

  // Inclusive tolerance window test on an unsigned absolute difference.
  function automatic logic within_tol(input logic [CNT_W-1:0] value,
                                      input logic [CNT_W:0]   nominal);
    logic [CNT_W:0] v;
    logic [CNT_W:0] diff;
    v    = {1'b0, value};
    diff = (v >= nominal) ? (v - nominal) : (nominal - v);
    return diff <= TOL_W;
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_lost;
  logic             capture;
  logic [CNT_W-1:0] candidate;

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             m1_q, m1_d;
  logic             m8_q, m8_d;
  logic             nosig_q, nosig_d;
  logic             overrun_q, overrun_d;
  logic             handshake;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, which is what makes the chain a chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise      = s2_q & ~s3_q;
  assign capture   = rise && (state_q == S_MEAS);
  assign candidate = cnt_q + CNT_ONE;

  // Measurement FSM next-state: idle until first edge, count between edges,
  // park in S_LOST (counter frozen) once the timeout elapses.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    set_lost = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rise) state_d = S_MEAS;
      end
      S_MEAS: begin
        if (rise) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_LOST;
          set_lost = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LOST: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = S_MEAS;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign handshake = valid_q & meas_ready;

  // Result register next-state: load a capture when the slot is free or is
  // being emptied this cycle, otherwise drop it and flag overrun.
  always_comb begin
    valid_d   = valid_q;
    period_d  = period_q;
    m1_d      = m1_q;
    m8_d      = m8_q;
    nosig_d   = nosig_q;
    overrun_d = overrun_q;
    if (handshake) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (capture) begin
      nosig_d = 1'b0;
      if (!valid_q || handshake) begin
        valid_d  = 1'b1;
        period_d = candidate;
        m1_d     = within_tol(candidate, P1_W);
        m8_d     = within_tol(candidate, P8_W);
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (set_lost) nosig_d = 1'b1;
  end

  // Result and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      period_q  <= '0;
      m1_q      <= 1'b0;
      m8_q      <= 1'b0;
      nosig_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      period_q  <= period_d;
      m1_q      <= m1_d;
      m8_q      <= m8_d;
      nosig_q   <= nosig_d;
      overrun_q <= overrun_d;
    end
  end

  assign meas_valid  = valid_q;
  assign period      = period_q;
  assign match_1khz  = m1_q;
  assign match_800hz = m8_q;
  assign no_signal   = nosig_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: table-driven period vectors feeding a scoreboard queue,
// plus hand-written sequences for timeout, restart, overrun, edge-at-timeout
// and asynchronous reset. Parameters are scaled down to keep runs short.
`timescale 1ns/1ps
module tb_tone_period_meter;

  localparam int CNT_W = 20;
  localparam int P1    = 400;
  localparam int P8    = 500;
  localparam int TOL   = 10;
  localparam int TO    = 2000;

  typedef struct {
    int   n;
    logic m1;
    logic m8;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             meas_ready;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic             match_1khz;
  logic             match_800hz;
  logic             no_signal;
  logic             overrun;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t exp_q[$];
  vec_t mon_e;
  vec_t tbl[11];

  tone_period_meter #(
    .CNT_W  (CNT_W),
    .P_1KHZ (P1),
    .P_800HZ(P8),
    .TOL    (TOL),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .period     (period),
    .match_1khz (match_1khz),
    .match_800hz(match_800hz),
    .no_signal  (no_signal),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1ns after posedge.
  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full square-wave period of n clks starting with a rising edge. The
  // measurement of this period appears when the following rising edge lands.
  task automatic wave(input int n, input bit push, input logic m1, input logic m8);
    vec_t e;
    if (push) begin
      e = '{n, m1, m8};
      exp_q.push_back(e);
    end
    sig_in = 1'b1;
    hold(n / 2);
    sig_in = 1'b0;
    hold(n - n / 2);
  endtask

  // Scoreboard consumer: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && meas_valid && meas_ready) begin
      check("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("period", period, mon_e.n);
        check("match_1khz", match_1khz, mon_e.m1);
        check("match_800hz", match_800hz, mon_e.m8);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{400, 1'b1, 1'b0};
    tbl[1]  = '{500, 1'b0, 1'b1};
    tbl[2]  = '{411, 1'b0, 1'b0};
    tbl[3]  = '{410, 1'b1, 1'b0};
    tbl[4]  = '{390, 1'b1, 1'b0};
    tbl[5]  = '{389, 1'b0, 1'b0};
    tbl[6]  = '{510, 1'b0, 1'b1};
    tbl[7]  = '{511, 1'b0, 1'b0};
    tbl[8]  = '{490, 1'b0, 1'b1};
    tbl[9]  = '{489, 1'b0, 1'b0};
    tbl[10] = '{450, 1'b0, 1'b0};

    rst        = 1'b1;
    sig_in     = 1'b0;
    meas_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_meas_valid", meas_valid, 0);
    check("rst_period", period, 0);
    check("rst_match_1khz", match_1khz, 0);
    check("rst_match_800hz", match_800hz, 0);
    check("rst_no_signal", no_signal, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    hold(2);

    // Steady periods around both tolerance windows.
    for (int i = 0; i < 11; i++) wave(tbl[i].n, 1'b1, tbl[i].m1, tbl[i].m8);

    // Last edge, then silence: no_signal exactly TO clks after the detected edge.
    sig_in = 1'b1;
    for (int k = 1; k <= TO + 3; k++) begin
      hold(1);
      if (k == 200) sig_in = 1'b0;
      if (k == TO + 2) check("nosig_before_timeout", no_signal, 0);
      if (k == TO + 3) check("nosig_at_timeout", no_signal, 1);
    end
    check("lost_valid_idle", meas_valid, 0);

    // Restart: first edge only restarts timing, flag clears with the first result.
    hold(50);
    exp_q.push_back('{400, 1'b1, 1'b0});
    sig_in = 1'b1;
    hold(10);
    check("nosig_after_first_edge", no_signal, 1);
    hold(190);
    sig_in = 1'b0;
    hold(200);
    exp_q.push_back('{400, 1'b1, 1'b0});
    sig_in = 1'b1;
    hold(2);
    check("nosig_before_second_edge", no_signal, 1);
    hold(1);
    check("nosig_cleared_on_result", no_signal, 0);
    hold(197);
    sig_in = 1'b0;
    hold(200);

    // Consumer stalls for three periods: first result held, later ones dropped.
    meas_ready = 1'b0;
    wave(420, 1'b0, 1'b0, 1'b0);
    wave(440, 1'b0, 1'b0, 1'b0);
    wave(460, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{480, 1'b0, 1'b0});
    sig_in = 1'b1;
    hold(5);
    check("stall_valid", meas_valid, 1);
    check("stall_period_held", period, 400);
    check("stall_match_held", match_1khz, 1);
    check("stall_overrun", overrun, 1);
    meas_ready = 1'b1;
    hold(1);
    meas_ready = 1'b0;
    check("pulse_valid_cleared", meas_valid, 0);
    check("pulse_overrun_cleared", overrun, 0);
    meas_ready = 1'b1;
    hold(234);
    sig_in = 1'b0;
    hold(240);

    // Period of exactly TO: the edge lands on the last count and wins.
    wave(TO, 1'b1, 1'b0, 1'b0);
    sig_in = 1'b1;
    hold(5);
    check("edge_at_timeout_nosig", no_signal, 0);
    hold(195);
    sig_in = 1'b0;
    hold(200);

    // Asynchronous reset while a result is pending.
    meas_ready = 1'b0;
    sig_in     = 1'b1;
    hold(100);
    check("pre_reset_valid", meas_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", meas_valid, 0);
    check("async_rst_period", period, 0);
    check("async_rst_match_1khz", match_1khz, 0);
    check("async_rst_overrun", overrun, 0);
    sig_in = 1'b0;
    hold(3);
    rst        = 1'b0;
    meas_ready = 1'b1;
    hold(5);
    exp_q.push_back('{400, 1'b1, 1'b0});
    sig_in = 1'b1;
    hold(200);
    sig_in = 1'b0;
    hold(200);
    sig_in = 1'b1;
    hold(2);
    check("no_result_before_second_edge", meas_valid, 0);
    hold(1);
    check("result_after_second_edge", meas_valid, 1);
    hold(20);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
Measures the period of an incoming square wave, counted in cycles of the 25MHz system clock. Typical sources are the 1kHz timing tick, the 800Hz buzzer tone, or an external pin. The input is synchronised, each rising edge is detected, and the clock cycles between consecutive rising edges are counted. Each result is classified against the two nominal tone periods and delivered over a valid/ready interface, with loss-of-signal and overrun flags. The block serves as the self-check/monitor for the tone and timing generation path.

Parameters:
CNT_W, 20, width of period counter and result
P_1KHZ, 25000, nominal 1kHz period in clk cycles
P_800HZ, 31250, nominal 800Hz period in clk cycles
TOL, 250, match tolerance in cycles, inclusive
TIMEOUT, 250000, cycles without rising edge before loss-of-signal (10ms)

Ports:
clk  in  1  25MHz system clock
rst  in  1  asynchronous reset, active-high
sig_in  in  1  asynchronous square wave to measure
meas_ready  in  1  consumer accepts result
meas_valid  out  1  result register holds an unread measurement
period  out  CNT_W  measured period in clk cycles
match_1khz  out  1  result within TOL of P_1KHZ
match_800hz  out  1  result within TOL of P_800HZ
no_signal  out  1  loss-of-signal flag
overrun  out  1  sticky: a measurement was dropped

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All state updates on posedge clk.
- Reset values: all outputs 0. Synchroniser flops 0. Counter 0. FSM in S_IDLE.
- Synchroniser: sig_in passes through 2 flops (s1, s2), plus a history flop s3.
  - edge = s2 & ~s3.
  - A sig_in rise is seen as edge 3 clks later.
- FSM states:
  - S_IDLE: cnt held 0. On edge: cnt<=0, go S_MEAS. The first edge only starts timing; no result is produced.
  - S_MEAS: cnt increments every clk.
    - On edge: capture candidate = cnt+1, cnt<=0, stay in S_MEAS.
    - Else if cnt == TIMEOUT-1: go S_LOST, no_signal<=1, cnt holds.
  - S_LOST: cnt held. On edge: cnt<=0, go S_MEAS. no_signal remains 1 until the next captured measurement.
- Edge and timeout in the same cycle: the edge wins (capture, no transition to S_LOST).
- Arithmetic:
  - cnt saturates at TIMEOUT-1; CNT_W must hold TIMEOUT.
  - A sig_in with a period of N clks yields period = N exactly, for steady N < TIMEOUT.
- Classification: computed on the candidate and registered together with period.
  - match_x = (|candidate - P_x| <= TOL), using unsigned compare on a widened difference.
  - Both matches may be 1 only if the tolerance windows overlap (not the case at defaults).
- Result capture (1 clk after edge):
  - If meas_valid==0, or meas_valid & meas_ready in the same cycle: load period/match regs, meas_valid<=1, no_signal<=0.
  - Otherwise: candidate dropped, overrun<=1, result regs unchanged; no_signal still clears.
- Handshake:
  - meas_valid & meas_ready with no new capture: meas_valid<=0, overrun<=0.
  - With a simultaneous capture: meas_valid stays 1, overrun<=0, new data is loaded.
  - period and match outputs are stable while meas_valid=1 and meas_ready=0.
- Loss of signal does not invalidate a pending result.
- Reset mid-measurement: everything returns to reset values immediately. The first post-reset edge only restarts timing.

Test Plan:
- sig_in toggles every 12500 clks (1kHz), meas_ready=1 -> first result after the 2nd rising edge; period=25000, match_1khz=1, match_800hz=0; one result per 25000 clks.
- sig_in at 800Hz (toggle every 15625) -> period=31250, match_800hz=1, match_1khz=0. Period 25251 -> both match 0. Period 25250 -> match_1khz=1.
- sig_in held low after measurements -> no_signal=1 exactly TIMEOUT clks after the last detected edge. Then restart at 1kHz -> no_signal clears with the first new result (2nd edge), not the 1st.
- meas_ready=0 across 3 periods -> meas_valid=1, period holds the first value, overrun=1. A single ready pulse -> handshake, overrun=0, and the next result loads.
- Rising edge arriving on the exact cycle cnt==TIMEOUT-1 -> period=TIMEOUT captured, no_signal stays 0.
- rst asserted mid-period while meas_valid=1 -> all outputs 0 asynchronously. After release, 1kHz input -> no result until the 2nd post-reset edge, then period=25000.
